// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution kernel and its sequencing controller.
// The kernel wrapper imports KLAT_DEFAULT from here so both agree on pipeline depth.
package conv_pkg;

    localparam int KLAT_DEFAULT   = 4;
    localparam int DIM_W_DEFAULT  = 8;
    localparam int ADDR_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } state_t;

endpackage

// File: rtl/conv_tag_pipe.sv
// Valid/address delay line that shadows the kernel's multiply/adder-tree pipeline.
// Stage 0 captures the issue tag; the last stage lines up with the kernel result.
module conv_tag_pipe #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             inflight
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];

    // NOTE: the address stages are cleared along with the valids because the
    // last stage drives wr_addr directly, which must read zero after reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            dat[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    // Only stages ahead of the output count: a tag sitting in the last stage
    // is being written this cycle and will be gone after the edge.
    // NOTE: inflight gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) inflight = inflight | vld[i];
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/conv_sched.sv
// Sequencing controller for the 3x3 fp16 convolution kernel: job FSM, raster
// counters, ofmap write pointer and the tag pipe that aligns writes with ofmap_ch1.
module conv_sched
    import conv_pkg::*;
#(
    parameter int KLAT   = KLAT_DEFAULT,
    parameter int DIM_W  = DIM_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [ADDR_W-1:0] cfg_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              win_valid,
    output logic              win_ready,
    output logic              k_issue,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    state_t            state;
    logic [DIM_W-1:0]  oh, ow, row, col;
    logic [ADDR_W-1:0] wptr;
    logic              run_q, busy_q, done_q, err_q;
    logic              inflight, cfg_ok, col_last, last_win;

    assign cfg_ok   = (cfg_h >= DIM_W'(3)) && (cfg_w >= DIM_W'(3));
    assign col_last = (col == ow - DIM_W'(1));
    assign last_win = col_last && (row == oh - DIM_W'(1));

    // Abort must win over a concurrent window, so it gates ready combinationally.
    assign win_ready = run_q & ~abort;
    assign k_issue   = win_valid & win_ready;

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

    // NOTE: every register here uses <= so all state updates see the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            run_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            oh     <= '0;
            ow     <= '0;
            row    <= '0;
            col    <= '0;
            wptr   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (abort) begin
                state  <= ST_IDLE;
                run_q  <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (start) begin
                        row  <= '0;
                        col  <= '0;
                        oh   <= cfg_h - DIM_W'(2);
                        ow   <= cfg_w - DIM_W'(2);
                        wptr <= cfg_base;
                        if (cfg_ok) begin
                            state  <= ST_RUN;
                            run_q  <= 1'b1;
                            busy_q <= 1'b1;
                        end else begin
                            state  <= ST_FIN;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end
                    end
                    ST_RUN: if (k_issue) begin
                        wptr <= wptr + ADDR_W'(1);
                        if (col_last) begin
                            col <= '0;
                            row <= row + DIM_W'(1);
                        end else begin
                            col <= col + DIM_W'(1);
                        end
                        if (last_win) begin
                            state <= ST_DRAIN;
                            run_q <= 1'b0;
                        end
                    end
                    ST_DRAIN: if (!inflight) begin
                        state  <= ST_FIN;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    conv_tag_pipe #(
        .DEPTH (KLAT),
        .WIDTH (ADDR_W)
    ) u_tag_pipe (
        .clk       (clk),
        .clr       (~rst_n | abort),
        .in_valid  (k_issue),
        .in_data   (wptr),
        .out_valid (wr_en),
        .out_data  (wr_addr),
        .inflight  (inflight)
    );

endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched: a scoreboard of expected {cycle, address}
// writes is filled as windows are handshaken and drained by a write monitor.
module tb_conv_sched;

    localparam int KLAT   = 4;
    localparam int DIM_W  = 8;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [DIM_W-1:0]  cfg_h = '0;
    logic [DIM_W-1:0]  cfg_w = '0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic              busy, done, err;
    logic              win_valid = 1'b0;
    logic              win_ready, k_issue, wr_en;
    logic [ADDR_W-1:0] wr_addr;

    typedef struct {
        int               cyc;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic mon_exp;

    conv_sched #(
        .KLAT   (KLAT),
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_h     (cfg_h),
        .cfg_w     (cfg_w),
        .cfg_base  (cfg_base),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .k_issue   (k_issue),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Write monitor: every wr_en must match the head of the scoreboard in cycle and address.
    always @(negedge clk) begin
        mon_exp = (q.size() > 0) && (q[0].cyc == cyc);
        if (mon_exp || wr_en) begin
            check("wr_en", 32'(wr_en), 32'(mon_exp));
            if (mon_exp) begin
                check("wr_addr", 32'(wr_addr), 32'(q[0].addr));
                void'(q.pop_front());
            end
        end
    end

    task automatic run_job(input int h, input int w, input logic [ADDR_W-1:0] base,
                           input bit toggle, input int abort_after, input bit start_mid);
        int                oh, ow, total, n, last_hs, budget;
        bit                ab, legal;
        logic [ADDR_W-1:0] addr;
        oh      = h - 2;
        ow      = w - 2;
        legal   = (h >= 3) && (w >= 3);
        total   = legal ? oh * ow : 0;
        n       = 0;
        last_hs = 0;
        addr    = base;

        @(posedge clk); #1;
        start    = 1'b1;
        cfg_h    = DIM_W'(h);
        cfg_w    = DIM_W'(w);
        cfg_base = base;
        @(negedge clk);
        check("idle_ready", 32'(win_ready), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));
        @(posedge clk); #1;
        start    = 1'b0;
        cfg_h    = DIM_W'($urandom);
        cfg_w    = DIM_W'($urandom);
        cfg_base = ADDR_W'($urandom);

        if (!legal) begin
            @(negedge clk);
            check("bad_done", 32'(done), 32'(1));
            check("bad_err", 32'(err), 32'(1));
            check("bad_busy", 32'(busy), 32'(0));
            check("bad_ready", 32'(win_ready), 32'(0));
            @(posedge clk); #1;
            @(negedge clk);
            check("bad_done_clr", 32'(done), 32'(0));
            check("bad_busy2", 32'(busy), 32'(0));
            return;
        end

        budget = 4 * total + 10;
        for (int cy = 0; n < total && cy < budget; cy++) begin
            if (cy > 0) begin
                @(posedge clk); #1;
            end
            win_valid = toggle ? (cy % 2 == 0) : 1'b1;
            ab        = (abort_after >= 0) && (n == abort_after);
            abort     = ab;
            start     = start_mid && (cy == 2);
            if (start_mid && cy == 2) begin
                cfg_h    = DIM_W'(3);
                cfg_w    = DIM_W'(3);
                cfg_base = ADDR_W'(16'h0055);
            end
            @(negedge clk);
            check("run_ready", 32'(win_ready), 32'(!ab));
            check("run_busy", 32'(busy), 32'(1));
            check("k_issue", 32'(k_issue), 32'(win_valid && !ab));
            if (ab) begin
                q.delete();
                @(posedge clk); #1;
                abort     = 1'b0;
                win_valid = 1'b0;
                for (int i = 0; i < 2 * KLAT; i++) begin
                    @(negedge clk);
                    check("abort_busy", 32'(busy), 32'(0));
                    check("abort_done", 32'(done), 32'(0));
                    check("abort_ready", 32'(win_ready), 32'(0));
                    @(posedge clk); #1;
                end
                return;
            end
            if (win_valid) begin
                q.push_back('{cyc: cyc + KLAT, addr: addr});
                addr++;
                n++;
                last_hs = cyc;
            end
        end
        check("hs_count", 32'(n), 32'(total));

        @(posedge clk); #1;
        win_valid = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        check("drain_ready", 32'(win_ready), 32'(0));
        for (int i = 0; i < KLAT + 20 && !done; i++) @(negedge clk);
        check("done_cyc", 32'(cyc), 32'(last_hs + KLAT + 1));
        check("done", 32'(done), 32'(1));
        check("fin_busy", 32'(busy), 32'(0));
        check("fin_err", 32'(err), 32'(0));
        check("sb_empty", 32'(q.size()), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("done_clr", 32'(done), 32'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_ready", 32'(win_ready), 32'(0));
        check("rst_kissue", 32'(k_issue), 32'(0));
        check("rst_wr_en", 32'(wr_en), 32'(0));
        check("rst_wr_addr", 32'(wr_addr), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_job(4, 4, 16'h0100, 1'b0, -1, 1'b0);
        run_job(5, 6, 16'h0200, 1'b1, -1, 1'b0);
        run_job(4, 2, 16'h0300, 1'b0, -1, 1'b0);
        run_job(2, 7, 16'h0300, 1'b0, -1, 1'b0);
        run_job(5, 6, 16'h0300, 1'b0, 3, 1'b0);
        run_job(4, 4, 16'h0400, 1'b0, -1, 1'b0);
        run_job(4, 4, 16'hFFFE, 1'b0, -1, 1'b0);
        run_job(5, 5, 16'h0010, 1'b0, -1, 1'b1);

        repeat (KLAT + 2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
